// File: rtl/float16_argmax_judge_pkg.sv
// Shared float16 field layout, constants and judge FSM state type.
// Imported by the comparator, the stream interface and the argmax judge.
package float16_pkg;

    localparam int FP16_W   = 16;
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MANT_MSB = 9;
    localparam int MANT_LSB = 0;

    localparam logic [FP16_W-1:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_NEG_ZERO = 16'h8000;

    typedef logic [FP16_W-1:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } judge_state_t;

endpackage

// File: rtl/float16_argmax_judge_if.sv
// Score stream in, top-1 result out. The slave modport is the judge side;
// the master modport is the producer/consumer side.
interface float16_argmax_judge_if
    import float16_pkg::*;
#(
    parameter int NUM_SCORES = 16,
    parameter int IDX_W      = $clog2(NUM_SCORES)
);

    fp16_t             threshold;
    logic              in_valid;
    logic              in_ready;
    fp16_t             in_score;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    fp16_t             out_max;
    logic [IDX_W-1:0]  out_idx;
    logic              out_detect;
    logic              out_err;

    modport master (
        output threshold, in_valid, in_score, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_detect, out_err
    );

    modport slave (
        input  threshold, in_valid, in_score, in_last, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_detect, out_err
    );

endinterface

// File: rtl/float16_argmax_judge_lt.sv
// Strict total-order "a < b" on raw float16 bit patterns: sign first, then
// magnitude (reversed for negatives). NaN/Inf get no special treatment.
module float16_lt
    import float16_pkg::*;
(
    input  fp16_t i_a,
    input  fp16_t i_b,
    output logic  o_lt
);

    always_comb begin
        o_lt = 1'b0;
        if (i_a[SIGN_BIT] != i_b[SIGN_BIT]) begin
            o_lt = i_a[SIGN_BIT];
        end else if (!i_a[SIGN_BIT]) begin
            o_lt = (i_a[EXP_MSB:MANT_LSB] < i_b[EXP_MSB:MANT_LSB]);
        end else begin
            o_lt = (i_a[EXP_MSB:MANT_LSB] > i_b[EXP_MSB:MANT_LSB]);
        end
    end

endmodule

// File: rtl/float16_argmax_judge.sv
// Streaming top-1 selector: tracks the running max of a fixed-length score
// frame and presents max, index, threshold judge and framing error.
module float16_argmax_judge
    import float16_pkg::*;
#(
    parameter int NUM_SCORES = 16,
    parameter int IDX_W      = $clog2(NUM_SCORES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    float16_argmax_judge_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_SCORES - 1);

    judge_state_t      r_state;
    fp16_t             r_threshold;
    fp16_t             r_max;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_errAcc;
    logic              r_outValid;
    fp16_t             r_outMax;
    logic [IDX_W-1:0]  r_outIdx;
    logic              r_outDetect;
    logic              r_outErr;

    logic              w_beat;
    logic              w_maxLt;
    logic              w_detect;
    logic              w_isLastBeat;
    logic              w_nextErr;
    fp16_t             w_nextMax;
    logic [IDX_W-1:0]  w_nextIdx;

    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign bus.in_ready = rst_n && (r_state != HOLD);
    assign w_beat       = bus.in_valid && bus.in_ready;

    float16_lt u_maxLt (
        .i_a  (r_max),
        .i_b  (bus.in_score),
        .o_lt (w_maxLt)
    );

    assign w_nextMax    = w_maxLt ? bus.in_score : r_max;
    assign w_nextIdx    = w_maxLt ? r_cnt : r_idx;
    assign w_isLastBeat = (r_cnt == LAST_CNT);
    assign w_nextErr    = r_errAcc | (bus.in_last != w_isLastBeat);

    float16_lt u_judgeLt (
        .i_a  (r_threshold),
        .i_b  (w_nextMax),
        .o_lt (w_detect)
    );

    // Frame end is purely count based; in_last only feeds the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_threshold <= FP16_POS_ZERO;
            r_max       <= FP16_POS_ZERO;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_errAcc    <= 1'b0;
            r_outValid  <= 1'b0;
            r_outMax    <= FP16_POS_ZERO;
            r_outIdx    <= '0;
            r_outDetect <= 1'b0;
            r_outErr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        r_threshold <= bus.threshold;
                        r_max       <= bus.in_score;
                        r_idx       <= '0;
                        r_cnt       <= IDX_W'(1);
                        r_errAcc    <= bus.in_last;
                        r_state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_max    <= w_nextMax;
                        r_idx    <= w_nextIdx;
                        r_errAcc <= w_nextErr;
                        if (w_isLastBeat) begin
                            r_outMax    <= w_nextMax;
                            r_outIdx    <= w_nextIdx;
                            r_outDetect <= w_detect;
                            r_outErr    <= w_nextErr;
                            r_outValid  <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (r_outValid && bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid  = r_outValid;
    assign bus.out_max    = r_outMax;
    assign bus.out_idx    = r_outIdx;
    assign bus.out_detect = r_outDetect;
    assign bus.out_err    = r_outErr;

endmodule

// File: tb/tb_float16_argmax_judge.sv
// Self-checking bench for float16_argmax_judge with NUM_SCORES=4: directed
// frames, backpressure, resets and random back-to-back frames vs a model.
module tb_float16_argmax_judge;
    import float16_pkg::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    float16_argmax_judge_if #(.NUM_SCORES(N), .IDX_W(IW)) ifc ();

    float16_argmax_judge #(.NUM_SCORES(N), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] frameScores [N];
    logic        frameLast   [N];
    logic [15:0] frameThr;
    int          gapPct = 0;

    logic [15:0] expMax;
    int          expIdx;
    logic        expDetect;
    logic        expErr;

    logic [15:0] dScores [6][4] = '{
        '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00},
        '{16'h3C00, 16'h3C00, 16'h3800, 16'h3C00},
        '{16'hC000, 16'hBC00, 16'h8000, 16'h0000},
        '{16'hC000, 16'hBC00, 16'h8000, 16'hC000},
        '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00},
        '{16'hBC00, 16'hC000, 16'h3800, 16'h3801}
    };
    logic [3:0]  dLast [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b1000};
    logic [15:0] dThr  [6] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h0000, 16'h3C00, 16'h3800};
    logic [15:0] dMax  [6] = '{16'h4000, 16'h3C00, 16'h0000, 16'h8000, 16'h4000, 16'h3801};
    int          dIdx  [6] = '{1, 0, 3, 2, 1, 3};
    logic        dDet  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        dErr  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Maps a float16 bit pattern onto an integer rank: all negatives below
    // all positives, negatives ranked by descending magnitude.
    function automatic int orderKey(logic [15:0] v);
        return v[15] ? (32767 - int'(v[14:0])) : (32768 + int'(v[14:0]));
    endfunction

    function automatic void computeExpected();
        expMax = frameScores[0];
        expIdx = 0;
        expErr = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (orderKey(frameScores[i]) > orderKey(expMax)) begin
                expMax = frameScores[i];
                expIdx = i;
            end
            if (frameLast[i] != (i == N - 1)) expErr = 1'b1;
        end
        expDetect = (orderKey(frameThr) < orderKey(expMax));
    endfunction

    function automatic logic [15:0] randScore();
        case ($urandom_range(7))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'h3C00;
            3:       return 16'hBC00;
            default: return 16'($urandom);
        endcase
    endfunction

    // Drives one frame from frameScores/frameLast, with optional bubbles,
    // and scrambles threshold after the first beat.
    task automatic applyStimulus();
        int guard;
        ifc.threshold = frameThr;
        for (int i = 0; i < N; i++) begin
            if (gapPct > 0 && $urandom_range(99) < gapPct) begin
                ifc.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            ifc.in_valid = 1'b1;
            ifc.in_score = frameScores[i];
            ifc.in_last  = frameLast[i];
            guard = 0;
            while (ifc.in_ready !== 1'b1 && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            checks++;
            if (guard >= 20) begin
                errors++;
                $display("[TB] FAIL in_ready_timeout: beat %0d in_ready=%b, required 1 within 20 cycles", i, ifc.in_ready);
            end
            if (i == N - 1) begin
                checks++;
                if (ifc.out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL early_out_valid: out_valid=%b before last beat, required 0", ifc.out_valid);
                end
            end
            @(posedge clk); #1;
            if (i == 0) ifc.threshold = 16'($urandom);
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic releaseResult();
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ifc.threshold = '0;
        ifc.in_valid  = 1'b0;
        ifc.in_score  = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({ifc.in_ready, ifc.out_valid, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: rdy=%b vld=%b max=%h idx=%0d det=%b err=%b, required all 0",
                     ifc.in_ready, ifc.out_valid, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err);
        end
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", ifc.in_ready, ifc.out_valid);
        end
    endtask

    task automatic test_directed();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                frameScores[i] = dScores[c][i];
                frameLast[i]   = dLast[c][i];
            end
            frameThr = dThr[c];
            applyStimulus();
            checks++;
            if ({ifc.out_valid, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err} !==
                {1'b1, dMax[c], IW'(dIdx[c]), dDet[c], dErr[c]}) begin
                errors++;
                $display("[TB] FAIL directed_%0d: got vld=%b max=%h idx=%0d det=%b err=%b, required vld=1 max=%h idx=%0d det=%b err=%b",
                         c, ifc.out_valid, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err,
                         dMax[c], dIdx[c], dDet[c], dErr[c]);
            end
            releaseResult();
            checks++;
            if ({ifc.out_valid, ifc.in_ready, ifc.out_max} !== {1'b0, 1'b1, dMax[c]}) begin
                errors++;
                $display("[TB] FAIL directed_release_%0d: vld=%b rdy=%b max=%h, required 0/1/%h",
                         c, ifc.out_valid, ifc.in_ready, ifc.out_max, dMax[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) begin
            frameScores[i] = randScore();
            frameLast[i]   = (i == N - 1);
        end
        frameThr = randScore();
        computeExpected();
        applyStimulus();
        ifc.in_valid = 1'b1;
        ifc.in_score = 16'h7BFF;
        ifc.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({ifc.out_valid, ifc.in_ready, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err} !==
                {1'b1, 1'b0, expMax, IW'(expIdx), expDetect, expErr}) begin
                errors++;
                $display("[TB] FAIL backpressure_hold_%0d: vld=%b rdy=%b max=%h idx=%0d det=%b, required 1/0/%h/%0d/%b",
                         k, ifc.out_valid, ifc.in_ready, ifc.out_max, ifc.out_idx, ifc.out_detect,
                         expMax, expIdx, expDetect);
            end
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_no_bypass: in_ready=%b during transfer cycle, required 0", ifc.in_ready);
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b, required 1/0", ifc.in_ready, ifc.out_valid);
        end
    endtask

    task automatic test_reset_midframe();
        ifc.in_valid = 1'b1;
        ifc.in_last  = 1'b0;
        ifc.in_score = 16'h7C00;
        @(posedge clk); #1;
        ifc.in_score = 16'h7BFF;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midframe: out_valid=%b in_ready=%b, required 0/0", ifc.out_valid, ifc.in_ready);
        end
        ifc.in_valid = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            frameScores[i] = (i == 0) ? 16'h3800 : randScore() & 16'h37FF;
            frameLast[i]   = (i == N - 1);
        end
        frameThr = 16'h0000;
        computeExpected();
        applyStimulus();
        checks++;
        if ({ifc.out_valid, ifc.out_max, ifc.out_idx, ifc.out_err} !== {1'b1, expMax, IW'(expIdx), expErr}) begin
            errors++;
            $display("[TB] FAIL reset_midframe_next: vld=%b max=%h idx=%0d err=%b, required 1/%h/%0d/%b",
                     ifc.out_valid, ifc.out_max, ifc.out_idx, ifc.out_err, expMax, expIdx, expErr);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifc.out_valid, ifc.in_ready, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_in_hold: vld=%b rdy=%b max=%h idx=%0d det=%b err=%b, required all 0",
                     ifc.out_valid, ifc.in_ready, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err);
        end
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int waitCycles;
        gapPct = 30;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                frameScores[i] = randScore();
                frameLast[i]   = (i == N - 1);
            end
            if ($urandom_range(4) == 0) frameLast[$urandom_range(N - 1)] = ~frameLast[$urandom_range(N - 1)];
            frameThr = randScore();
            computeExpected();
            applyStimulus();
            checks++;
            if ({ifc.out_valid, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err} !==
                {1'b1, expMax, IW'(expIdx), expDetect, expErr}) begin
                errors++;
                $display("[TB] FAIL random_frame_%0d: got vld=%b max=%h idx=%0d det=%b err=%b, required vld=1 max=%h idx=%0d det=%b err=%b thr=%h",
                         f, ifc.out_valid, ifc.out_max, ifc.out_idx, ifc.out_detect, ifc.out_err,
                         expMax, expIdx, expDetect, expErr, frameThr);
            end
            waitCycles = $urandom_range(2);
            repeat (waitCycles) begin
                @(posedge clk); #1;
            end
            releaseResult();
        end
        gapPct = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
